// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_pkg
//  Purpose  : Shared types and constants for the 4-to-1 round-robin gathering
//             mux (channel count, channel-index type, output-stage states).
//  Revision : 1.0  initial release
// ============================================================================
package mux_pkg;

    // Number of source channels merged onto the output link
    localparam int NCH = 4;

    // Channel index carried alongside every output word
    typedef logic [1:0] sel_t;

    // Output-stage state: the single output slot is either empty or holding a word
    typedef logic [0:0] state_t;
    localparam state_t EMPTY = 1'b0;
    localparam state_t FULL  = 1'b1;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/rr_arb4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb4
//  Purpose  : Combinational 4-way round-robin grant search. Picks the first
//             requesting channel starting at ptr and wrapping modulo 4.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb4
    import mux_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  sel_t           ptr,
    output sel_t           gnt_idx,
    output logic           any
);

    sel_t w_idx;

    // Scan from the farthest candidate back to ptr so the closest requester wins
    always_comb begin
        gnt_idx = ptr;
        w_idx   = ptr;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_idx = ptr + sel_t'(k);
            if (req[w_idx]) begin
                gnt_idx = w_idx;
            end
        end
    end

    assign any = |req;

endmodule : rr_arb4
`default_nettype wire

// File: rtl/mux_4a1_rr_n.sv
`default_nettype none
// ============================================================================
//  Module   : mux_4a1_rr_n
//  Purpose  : Merges four N-bit valid/ready source channels onto one
//             registered output stream, round-robin arbitrated, tagging each
//             word with the index of the channel that produced it.
//  Options  : MUX_PARITY_EN - adds registered even-parity output y_par.
//  Revision : 1.0  initial release
// ============================================================================
module mux_4a1_rr_n
    import mux_pkg::*;
#(
    parameter int N = 4
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] x0,
    input  logic [N-1:0] x1,
    input  logic [N-1:0] x2,
    input  logic [N-1:0] x3,
    input  logic         v0,
    input  logic         v1,
    input  logic         v2,
    input  logic         v3,
    output logic         r0,
    output logic         r1,
    output logic         r2,
    output logic         r3,
    output logic [N-1:0] y,
    output sel_t         y_sel,
    output logic         y_valid,
    input  logic         y_ready
`ifdef MUX_PARITY_EN
    ,
    output logic         y_par
`endif
);

    state_t       r_state;
    logic [N-1:0] r_y;
    sel_t         r_sel;
    sel_t         r_ptr;

    logic [NCH-1:0] w_req;
    sel_t           w_gnt;
    logic           w_any;
    logic           w_slot_free;
    logic           w_load;
    logic [N-1:0]   w_xg;

    assign w_req = {v3, v2, v1, v0};

    rr_arb4 u_arb (
        .req     (w_req),
        .ptr     (r_ptr),
        .gnt_idx (w_gnt),
        .any     (w_any)
    );

    // The slot accepts a word when empty or when its current word leaves this cycle
    assign w_slot_free = (r_state == EMPTY) || y_ready;
    assign w_load      = w_slot_free && w_any;

    assign r0 = w_load && (w_gnt == 2'd0);
    assign r1 = w_load && (w_gnt == 2'd1);
    assign r2 = w_load && (w_gnt == 2'd2);
    assign r3 = w_load && (w_gnt == 2'd3);

    // Select the granted channel's data for loading into the output register
    always_comb begin
        w_xg = x0;
        case (w_gnt)
            2'd0:    w_xg = x0;
            2'd1:    w_xg = x1;
            2'd2:    w_xg = x2;
            default: w_xg = x3;
        endcase
    end

    // Output slot, index tag and rotating pointer; a drain leaves y/y_sel untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_y     <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            r_state <= FULL;
            r_y     <= w_xg;
            r_sel   <= w_gnt;
            r_ptr   <= w_gnt + 2'd1;
        end else if ((r_state == FULL) && y_ready) begin
            r_state <= EMPTY;
        end
    end

    assign y       = r_y;
    assign y_sel   = r_sel;
    assign y_valid = (r_state == FULL);

`ifdef MUX_PARITY_EN
    logic r_par;

    // Even parity of the word being loaded, held alongside y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^w_xg;
        end
    end

    assign y_par = r_par;
`endif

endmodule : mux_4a1_rr_n
`default_nettype wire

// File: tb/tb_mux_4a1_rr_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_4a1_rr_n
//  Purpose  : Self-checking bench for mux_4a1_rr_n: a behavioural model of the
//             arbiter/output slot compared every cycle, plus directed vectors
//             with hand-computed expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_4a1_rr_n;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] x0, x1, x2, x3;
    logic         v0, v1, v2, v3;
    logic         r0, r1, r2, r3;
    logic [N-1:0] y;
    logic [1:0]   y_sel;
    logic         y_valid;
    logic         y_ready;
`ifdef MUX_PARITY_EN
    logic         y_par;
`endif

    int checks = 0;
    int errors = 0;

    mux_4a1_rr_n #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .x0      (x0),
        .x1      (x1),
        .x2      (x2),
        .x3      (x3),
        .v0      (v0),
        .v1      (v1),
        .v2      (v2),
        .v3      (v3),
        .r0      (r0),
        .r1      (r1),
        .r2      (r2),
        .r3      (r3),
        .y       (y),
        .y_sel   (y_sel),
        .y_valid (y_valid),
        .y_ready (y_ready)
`ifdef MUX_PARITY_EN
        ,
        .y_par   (y_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: one output slot, a rotating start index, and a
    // search that walks (ptr+k) mod 4. Checked and advanced on every
    // falling edge, where inputs and registered outputs are both stable.
    // ------------------------------------------------------------------
    int           m_ptr;
    logic         m_valid;
    logic [N-1:0] m_y;
    int           m_sel;
    logic         m_par;

    always @(negedge clk) begin
        logic [N-1:0] xs [4];
        logic [3:0]   vv;
        logic [3:0]   rr;
        int           g;
        logic         ld;
        if (!rst_n) begin
            m_ptr = 0; m_valid = 1'b0; m_y = '0; m_sel = 0; m_par = 1'b0;
            check("rst_y", y, 0);
            check("rst_sel", y_sel, 0);
            check("rst_valid", y_valid, 0);
            check("rst_r", {r3, r2, r1, r0}, 0);
        end else begin
            xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
            vv = {v3, v2, v1, v0};
            g = -1;
            for (int k = 0; k < 4; k++)
                if (g < 0 && vv[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            ld = (!m_valid || y_ready) && (g >= 0);
            rr = 4'b0000;
            if (ld) rr[g] = 1'b1;
            check("model_valid", y_valid, m_valid);
            check("model_y", y, m_y);
            check("model_sel", y_sel, m_sel);
            check("model_ready", {r3, r2, r1, r0}, rr);
`ifdef MUX_PARITY_EN
            check("model_par", y_par, m_par);
`endif
            if (ld) begin
                m_y = xs[g]; m_sel = g; m_valid = 1'b1; m_ptr = (g + 1) % 4;
                m_par = ^xs[g];
            end else if (m_valid && y_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_v(input logic [3:0] m);
        {v3, v2, v1, v0} = m;
    endtask

    // Directed pattern table: {valid mask, y_ready, x0..x3}
    logic [3:0] pat_v  [10] = '{4'b1010, 4'b1111, 4'b0000, 4'b0110, 4'b0001,
                                4'b1100, 4'b1100, 4'b0000, 4'b0011, 4'b0000};
    logic       pat_rd [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                                1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] fair_y [5]  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    logic [1:0] fair_s [5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] skip_s [3]  = '{2'd3, 2'd0, 2'd3};

    initial begin
        rst_n = 1'b0; y_ready = 1'b0;
        x0 = '0; x1 = '0; x2 = '0; x3 = '0;
        set_v(4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("lit_rst_valid", y_valid, 0);
        tick(); rst_n = 1'b1;
        @(negedge clk);

        // Single channel: r2 in the handshake cycle, word visible next cycle
        tick(); x2 = 4'h5; set_v(4'b0100); y_ready = 1'b1;
        @(negedge clk);
        check("lit_single_r2", r2, 1);
        check("lit_single_r0", r0, 0);
        tick(); set_v(4'b0000);
        @(negedge clk);
        check("lit_single_y", y, 4'h5);
        check("lit_single_sel", y_sel, 2);
        check("lit_single_valid", y_valid, 1);

        // Drain, then move ptr from 3 to 1 by loading channel 0
        tick(); x0 = 4'h7; set_v(4'b0001);
        @(negedge clk);
        check("lit_drain_valid", y_valid, 0);
        check("lit_drain_y_hold", y, 4'h5);
        check("lit_ptr3_r0", r0, 1);

        // Pointer skip: only 0 and 3 valid with ptr=1 -> 3, 0, 3
        tick(); set_v(4'b1001); x0 = 4'h8; x3 = 4'h9;
        @(negedge clk);
        check("lit_skip_first_r3", r3, 1);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                tick(); set_v(4'b1111); x0 = 4'd1; x1 = 4'd2; x2 = 4'd3; x3 = 4'd4;
            end else begin
                tick();
            end
            @(negedge clk);
            check("lit_skip_sel", y_sel, skip_s[i]);
        end

        // Fairness with all valid: 0,1,2,3,0 back to back, no bubbles
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 4) begin
                set_v(4'b1000); x3 = 4'h3;
            end
            @(negedge clk);
            check("lit_fair_sel", y_sel, fair_s[i]);
            check("lit_fair_y", y, fair_y[i]);
            check("lit_fair_valid", y_valid, 1);
        end

        // Backpressure: y=3 held for three stalled cycles with v0,v1 pending
        tick(); set_v(4'b0011); x0 = 4'h6; x1 = 4'h7; y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            check("lit_bp_y", y, 4'h3);
            check("lit_bp_r01", {r1, r0}, 2'b00);
        end
        tick(); y_ready = 1'b1;
        @(negedge clk);
        check("lit_bp_release_r0", r0, 1);
        tick(); set_v(4'b0000);
        @(negedge clk);
        check("lit_bp_next_y", y, 4'h6);
        check("lit_bp_next_sel", y_sel, 0);

        // Asynchronous reset while holding y=A
        tick(); x2 = 4'hA; set_v(4'b0100);
        tick(); set_v(4'b0000); y_ready = 1'b0;
        @(negedge clk);
        check("lit_hold_y", y, 4'hA);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("lit_async_y", y, 0);
        check("lit_async_sel", y_sel, 0);
        check("lit_async_valid", y_valid, 0);
        @(negedge clk);
        tick(); rst_n = 1'b1;

        // Directed pattern table, checked by the model every cycle
        x0 = 4'hC; x1 = 4'h3; x2 = 4'hE; x3 = 4'h1;
        for (int i = 0; i < 10; i++) begin
            tick(); set_v(pat_v[i]); y_ready = pat_rd[i];
            x0 = x0 + 4'd1; x3 = x3 ^ 4'h5;
        end
        tick(); set_v(4'b0000); y_ready = 1'b1;
        tick();

`ifdef MUX_PARITY_EN
        tick(); x1 = 4'b0111; set_v(4'b0010);
        tick(); set_v(4'b0000);
        @(negedge clk);
        check("lit_par_odd", y_par, 1);
        tick(); x1 = 4'b0110; set_v(4'b0010);
        tick(); set_v(4'b0000);
        @(negedge clk);
        check("lit_par_even", y_par, 0);
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule : tb_mux_4a1_rr_n
`default_nettype wire

// File: doc/mux_4a1_rr_n.md
Name: mux_4a1_rr_n

Overview:
- Gathering counterpart to the 1-to-4 demux: merges four N-bit source channels onto one N-bit output stream.
- Uses a round-robin arbiter and valid/ready handshakes on every channel.
- The output carries the granted channel index (`y_sel`), so a downstream 1-to-4 demux can route each word back by index.
- Sits between four producers and one shared registered output link.

Parameters:
- N, 4, data width of each channel and of the output.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- x0, x1, x2, x3  in  N each  channel data.
- v0, v1, v2, v3  in  1 each  channel valid.
- r0, r1, r2, r3  out  1 each  channel ready; a channel transfers when vi && ri.
- y  out  N  registered output data.
- y_sel  out  2  index of the channel that produced y.
- y_valid  out  1  output valid.
- y_ready  in  1  downstream ready; an output transfers when y_valid && y_ready.

Behaviour:
- Reset (async, rst_n=0): y=0, y_sel=0, y_valid=0, rr pointer ptr=0. Any held word is discarded. Outputs stay at reset values until the first rising clk after rst_n goes high.
- Output stage state machine:
  - EMPTY (y_valid=0) and FULL (y_valid=1).
  - Slot free: slot_free = !y_valid || y_ready.
  - Request present: any_v = v0|v1|v2|v3.
  - Load: load = slot_free && any_v.
- Grant g: the first i with vi=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- ri = load && (g==i), combinational. At most one ri is high per cycle. ri is never high while vi=0.
- On load, at the clock edge: y <= x_g, y_sel <= g, y_valid <= 1, ptr <= (g+1) mod 4. FULL then stays FULL.
- FULL with y_ready=1 and no request: y_valid <= 0, go to EMPTY. y and y_sel keep their last values.
- FULL with y_ready=0: y, y_sel and y_valid hold stable; all ri=0.
- EMPTY with no request: nothing changes.
- Latency: 1 cycle from input handshake to y_valid.
- Throughput: 1 word/cycle while y_ready=1 (back-to-back loads with simultaneous drain).
- ptr advances only on a load, never on idle cycles.
- Fairness: with all four channels continuously valid, grants rotate 0,1,2,3,0,...
- Simultaneous load and drain in the same cycle: the new word replaces the drained word and y_valid stays 1.
- Inputs are sampled only at the handshake; the source may change x after its ri cycle.
- Combinational path y_ready -> ri is accepted; no skid buffer.

Optional Feature:
- Macro: MUX_PARITY_EN.
- Defined:
  - Adds output port y_par (1 bit), registered alongside y.
  - On each load, y_par <= ^x_g (even parity: y_par is the XOR of all bits of y).
  - Reset value 0; holds with y.
- Undefined: port y_par and its register are absent; all other behaviour is identical.

Decomposition:
- Package mux_pkg:
  - constant NCH=4;
  - typedef sel_t = logic [1:0];
  - state enum {EMPTY, FULL}.
- Sub-module rr_arb4: purely combinational.
  - Inputs: req[3:0], ptr.
  - Outputs: gnt_idx (sel_t), any.
- The top level owns the ptr register, the output register, the ri decode and the optional parity.

Test Plan:
- Reset mid-stream: y_valid=1 holding y=4'hA, assert rst_n=0 asynchronously -> y=0, y_sel=0, y_valid=0 immediately, with no clk edge needed.
- Single channel: v2=1, x2=4'h5, y_ready=1 -> r2=1 that cycle; next cycle y=4'h5, y_sel=2, y_valid=1, ptr=3.
- All valid, y_ready=1, x0..x3=1,2,3,4 -> y_sel sequence 0,1,2,3,0 on consecutive cycles, y=1,2,3,4,1, no bubbles.
- Backpressure: FULL with y=4'h3, y_ready=0 for 3 cycles, v0=v1=1 -> r0=r1=0, y=4'h3 stable. When y_ready returns to 1, the next word loads in the same cycle.
- Pointer skip: ptr=1, only v0 and v3 valid -> grant 3 first (search order 1,2,3), then 0, then 3.
- MUX_PARITY_EN defined: load x1=4'b0111 -> y_par=1; load x1=4'b0110 -> y_par=0.
